channel_event_arbiter: RTL and testbench

Parametrised successor to the fixed 64-channel ADC-to-digital hand-off in the pixel chip. It sits between the analog core's per-channel ADC outputs (`dout`, `done`) and the event builder / main FIFO in the digital core. Each channel gets its own local FIFO of configurable depth, and every stored conversion is timestamped. A round-robin arbiter serialises all channels into one valid/ready event stream. The block also reports per-channel full status and saturating drop statistics, which the current hand-off does not provide.

---
 rtl/event_arbiter_pkg.sv | 25 ++
 rtl/channel_event_arbiter_if.sv | 35 +++
 rtl/local_fifo.sv | 61 ++++++
 rtl/channel_event_arbiter.sv | 167 ++++++++++++++++
 tb/tb_channel_event_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/event_arbiter_pkg.sv
// Shared defaults and record layouts for the channel event arbiter.
package event_arbiter_pkg;

    localparam int unsigned DEF_NUMCHANNELS = 64;
    localparam int unsigned DEF_ADCBITS     = 10;
    localparam int unsigned DEF_FIFO_DEPTH  = 4;
    localparam int unsigned DEF_TS_W        = 32;
    localparam int unsigned DEF_CNT_W       = 16;
    localparam int unsigned DEF_CH_W        = $clog2(DEF_NUMCHANNELS);

    // One stored conversion in a local FIFO (default-width layout).
    typedef struct packed {
        logic [DEF_ADCBITS-1:0] data;
        logic [DEF_TS_W-1:0]    timestamp;
    } fifo_entry_t;

    // One event as presented on the output stream (default-width layout).
    typedef struct packed {
        logic [DEF_CH_W-1:0]    channel;
        logic [DEF_ADCBITS-1:0] data;
        logic [DEF_TS_W-1:0]    timestamp;
        logic                   overflow;
    } event_t;

endpackage

// File: rtl/channel_event_arbiter_if.sv
// Valid/ready event stream between the arbiter and the event builder.
interface channel_event_arbiter_if
    import event_arbiter_pkg::*;
#(
    parameter int unsigned CH_W   = DEF_CH_W,
    parameter int unsigned DATA_W = DEF_ADCBITS,
    parameter int unsigned TS_W   = DEF_TS_W
) ();

    logic              event_valid;
    logic              event_ready;
    logic [CH_W-1:0]   event_channel;
    logic [DATA_W-1:0] event_data;
    logic [TS_W-1:0]   event_timestamp;
    logic              event_overflow;

    modport master (
        output event_valid,
        output event_channel,
        output event_data,
        output event_timestamp,
        output event_overflow,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_channel,
        input  event_data,
        input  event_timestamp,
        input  event_overflow,
        output event_ready
    );

endinterface

// File: rtl/local_fifo.sv
// Per-channel FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module local_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_FULL);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage array; contents need no reset because occupancy is tracked separately.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/channel_event_arbiter.sv
// Per-channel timestamped capture FIFOs serialised by a round-robin arbiter into one event stream,
// with per-channel overflow tagging and a saturating drop counter.
module channel_event_arbiter
    import event_arbiter_pkg::*;
#(
    parameter int unsigned NUMCHANNELS      = DEF_NUMCHANNELS,
    parameter int unsigned ADCBITS          = DEF_ADCBITS,
    parameter int unsigned LOCAL_FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned TS_W             = DEF_TS_W,
    parameter int unsigned CNT_W            = DEF_CNT_W
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic [ADCBITS*NUMCHANNELS-1:0] i_dout,
    input  logic [NUMCHANNELS-1:0]         i_done,
    input  logic [NUMCHANNELS-1:0]         i_channel_mask,
    input  logic [TS_W-1:0]                i_timestamp,
    input  logic                           i_clear_drop_count,
    output logic [NUMCHANNELS-1:0]         o_fifo_full,
    output logic [CNT_W-1:0]               o_drop_count,
    channel_event_arbiter_if.master        evt
);

    localparam int unsigned CH_W  = $clog2(NUMCHANNELS);
    localparam int unsigned PC_W  = $clog2(NUMCHANNELS + 1);
    localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    // Entry layout at the configured widths.
    typedef struct packed {
        logic [ADCBITS-1:0] data;
        logic [TS_W-1:0]    timestamp;
    } entry_t;

    logic [NUMCHANNELS-1:0] w_push;
    logic [NUMCHANNELS-1:0] w_pop;
    logic [NUMCHANNELS-1:0] w_empty;
    logic [NUMCHANNELS-1:0] w_full;
    logic [NUMCHANNELS-1:0] w_drop;
    entry_t                 w_rdata [NUMCHANNELS];

    logic                   w_free;
    logic                   w_any;
    logic [CH_W-1:0]        w_sel;
    int unsigned            w_idx;

    logic [PC_W-1:0]        w_drop_cnt;
    logic [SUM_W-1:0]       w_cnt_sum;
    logic [CNT_W-1:0]       w_cnt_next;

    logic                   r_valid;
    logic [CH_W-1:0]        r_channel;
    logic [ADCBITS-1:0]     r_data;
    logic [TS_W-1:0]        r_timestamp;
    logic                   r_overflow;
    logic [CH_W-1:0]        r_last_grant;
    logic [NUMCHANNELS-1:0] r_ovf;
    logic [CNT_W-1:0]       r_drop_count;

    assign w_push = i_done & ~i_channel_mask;
    // A push on a full FIFO is only lost when that FIFO is not popped in the same cycle.
    assign w_drop = w_push & w_full & ~w_pop;
    assign w_free = ~r_valid | evt.event_ready;

    for (genvar g = 0; g < NUMCHANNELS; g++) begin : g_fifo
        entry_t w_wentry;
        assign w_wentry.data      = i_dout[g*ADCBITS +: ADCBITS];
        assign w_wentry.timestamp = i_timestamp;

        local_fifo #(
            .WIDTH ($bits(entry_t)),
            .DEPTH (LOCAL_FIFO_DEPTH)
        ) u_fifo (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .i_push    (w_push[g]),
            .i_pop     (w_pop[g]),
            .i_wdata   (w_wentry),
            .o_rdata   (w_rdata[g]),
            .o_empty   (w_empty[g]),
            .o_full    (w_full[g])
        );
    end

    // Round-robin search: first non-empty FIFO starting just after the last grant.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_idx = 0;
        for (int unsigned k = 1; k <= NUMCHANNELS; k++) begin
            w_idx = 32'(r_last_grant) + k;
            if (w_idx >= NUMCHANNELS) begin
                w_idx = w_idx - NUMCHANNELS;
            end
            if (!w_any && !w_empty[w_idx[CH_W-1:0]]) begin
                w_any = 1'b1;
                w_sel = w_idx[CH_W-1:0];
            end
        end
    end

    // One-hot pop of the granted FIFO whenever the output register can take a new event.
    always_comb begin
        w_pop = '0;
        if (w_free && w_any) begin
            w_pop[w_sel] = 1'b1;
        end
    end

    // Drop accounting: popcount of this cycle's drops added to the (possibly cleared) count.
    always_comb begin
        w_drop_cnt = '0;
        for (int unsigned i = 0; i < NUMCHANNELS; i++) begin
            w_drop_cnt = w_drop_cnt + PC_W'(w_drop[i]);
        end
        w_cnt_sum  = (i_clear_drop_count ? '0 : SUM_W'(r_drop_count)) + SUM_W'(w_drop_cnt);
        w_cnt_next = (w_cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
    end

    // Output register and grant pointer; loads only when free so outputs hold under backpressure.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_valid      <= 1'b0;
            r_channel    <= '0;
            r_data       <= '0;
            r_timestamp  <= '0;
            r_overflow   <= 1'b0;
            r_last_grant <= CH_W'(NUMCHANNELS - 1);
        end else if (w_free) begin
            r_valid <= w_any;
            if (w_any) begin
                r_channel    <= w_sel;
                r_data       <= w_rdata[w_sel].data;
                r_timestamp  <= w_rdata[w_sel].timestamp;
                r_overflow   <= r_ovf[w_sel];
                r_last_grant <= w_sel;
            end
        end
    end

    // Sticky overflow flags: a pop clears its channel, a same-cycle drop sets it again.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= (r_ovf & ~w_pop) | w_drop;
        end
    end

    // Saturating drop counter.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_drop_count <= '0;
        end else begin
            r_drop_count <= w_cnt_next;
        end
    end

    assign evt.event_valid     = r_valid;
    assign evt.event_channel   = r_channel;
    assign evt.event_data      = r_data;
    assign evt.event_timestamp = r_timestamp;
    assign evt.event_overflow  = r_overflow;
    assign o_fifo_full         = w_full;
    assign o_drop_count        = r_drop_count;

endmodule

// File: tb/tb_channel_event_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_channel_event_arbiter;
    import event_arbiter_pkg::*;

    localparam int unsigned NCH   = 64;
    localparam int unsigned AB    = 10;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TSW   = 32;
    localparam int unsigned CW    = 4;
    localparam int unsigned CHW   = 6;
    localparam int          CMAX  = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [AB*NCH-1:0] dout;
    logic [NCH-1:0]    done;
    logic [NCH-1:0]    mask;
    logic [TSW-1:0]    timestamp;
    logic              clear;
    logic [NCH-1:0]    fifo_full;
    logic [CW-1:0]     drop_count;

    channel_event_arbiter_if #(.CH_W(CHW), .DATA_W(AB), .TS_W(TSW)) evt ();

    channel_event_arbiter #(
        .NUMCHANNELS      (NCH),
        .ADCBITS          (AB),
        .LOCAL_FIFO_DEPTH (DEPTH),
        .TS_W             (TSW),
        .CNT_W            (CW)
    ) dut (
        .i_clk              (clk),
        .i_reset_n          (reset_n),
        .i_dout             (dout),
        .i_done             (done),
        .i_channel_mask     (mask),
        .i_timestamp        (timestamp),
        .i_clear_drop_count (clear),
        .o_fifo_full        (fifo_full),
        .o_drop_count       (drop_count),
        .evt                (evt.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // ---------------- reference model: per-channel queues, evaluated once per clock edge
    fifo_entry_t mq [NCH][$];
    bit          m_ovf [NCH];
    int          m_last;
    bit          m_valid;
    int          m_cnt;
    event_t      expq [$];

    always @(posedge clk) begin
        int          drops;
        int          c;
        bit          found;
        fifo_entry_t e;
        event_t      ev;
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                mq[i].delete();
                m_ovf[i] = 1'b0;
            end
            m_last  = NCH - 1;
            m_valid = 1'b0;
            m_cnt   = 0;
            expq.delete();
        end else begin
            drops = 0;
            found = 1'b0;
            if (!m_valid || evt.event_ready) begin
                for (int k = 1; k <= NCH; k++) begin
                    c = (m_last + k) % NCH;
                    if (!found && mq[c].size() > 0) begin
                        e            = mq[c].pop_front();
                        ev.channel   = CHW'(c);
                        ev.data      = e.data;
                        ev.timestamp = e.timestamp;
                        ev.overflow  = m_ovf[c];
                        m_ovf[c]     = 1'b0;
                        m_last       = c;
                        found        = 1'b1;
                        expq.push_back(ev);
                    end
                end
                m_valid = found;
            end
            for (int i = 0; i < NCH; i++) begin
                if (done[i] && !mask[i]) begin
                    if (mq[i].size() < DEPTH) begin
                        e.data      = dout[i*AB +: AB];
                        e.timestamp = timestamp;
                        mq[i].push_back(e);
                    end else begin
                        m_ovf[i] = 1'b1;
                        drops++;
                    end
                end
            end
            if (clear) m_cnt = 0;
            m_cnt = m_cnt + drops;
            if (m_cnt > CMAX) m_cnt = CMAX;
        end
    end

    // ---------------- monitor: compares status every cycle, events against the scoreboard
    always @(negedge clk) begin
        logic [NCH-1:0] full_exp;
        event_t         h;
        for (int i = 0; i < NCH; i++) full_exp[i] = (mq[i].size() == DEPTH);
        chk("mon_valid", evt.event_valid, m_valid);
        chk("mon_fifo_full", fifo_full, full_exp);
        chk("mon_drop_count", drop_count, m_cnt);
        if (evt.event_valid) begin
            if (expq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL mon_event: unexpected event ch %0d data 0x%0h, none expected",
                         evt.event_channel, evt.event_data);
            end else begin
                h = expq[0];
                chk("mon_channel", evt.event_channel, h.channel);
                chk("mon_data", evt.event_data, h.data);
                chk("mon_timestamp", evt.event_timestamp, h.timestamp);
                chk("mon_overflow", evt.event_overflow, h.overflow);
                if (evt.event_ready) void'(expq.pop_front());
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
        done      = '0;
        clear     = 1'b0;
        timestamp = timestamp + 1;
    endtask

    task automatic rand_dout();
        for (int i = 0; i < NCH; i++) dout[i*AB +: AB] = AB'($urandom);
    endtask

    task automatic expect_ev(input string tag, input int ch, input logic [AB-1:0] d,
                             input logic [TSW-1:0] ts, input bit ovf, input bit check_ts);
        chk({tag, "_valid"}, evt.event_valid, 1'b1);
        chk({tag, "_channel"}, evt.event_channel, ch);
        chk({tag, "_data"}, evt.event_data, d);
        if (check_ts) chk({tag, "_timestamp"}, evt.event_timestamp, ts);
        chk({tag, "_overflow"}, evt.event_overflow, ovf);
    endtask

    logic [AB-1:0]  d0, d1, d2, d63, d7;
    logic [TSW-1:0] ts0;

    initial begin
        reset_n         = 1'b0;
        done            = '0;
        mask            = '0;
        clear           = 1'b0;
        dout            = '0;
        timestamp       = '0;
        evt.event_ready = 1'b1;

        // Reset with random activity on done.
        repeat (2) begin
            done = {$urandom, $urandom};
            rand_dout();
            tick();
        end
        chk("rst_valid", evt.event_valid, 1'b0);
        chk("rst_channel", evt.event_channel, 0);
        chk("rst_data", evt.event_data, 0);
        chk("rst_timestamp", evt.event_timestamp, 0);
        chk("rst_overflow", evt.event_overflow, 1'b0);
        chk("rst_fifo_full", fifo_full, 0);
        chk("rst_drop_count", drop_count, 0);
        reset_n = 1'b1;

        // Round robin: channels 0, 1, 63 together, then 2 and 0.
        rand_dout();
        d0 = dout[0 +: AB]; d1 = dout[AB +: AB]; d63 = dout[63*AB +: AB];
        ts0 = timestamp;
        done[0] = 1'b1; done[1] = 1'b1; done[63] = 1'b1;
        tick();
        chk("rr_not_early", evt.event_valid, 1'b0);
        tick(); expect_ev("rr_first", 0, d0, ts0, 1'b0, 1'b1);
        tick(); expect_ev("rr_second", 1, d1, ts0, 1'b0, 1'b1);
        tick(); expect_ev("rr_third", 63, d63, ts0, 1'b0, 1'b1);
        tick(); chk("rr_idle", evt.event_valid, 1'b0);
        rand_dout();
        d0 = dout[0 +: AB]; d2 = dout[2*AB +: AB];
        done[0] = 1'b1; done[2] = 1'b1;
        tick();
        tick(); expect_ev("rr_wrap_a", 0, d0, 0, 1'b0, 1'b0);
        tick(); expect_ev("rr_wrap_b", 2, d2, 0, 1'b0, 1'b0);
        tick();

        // Single event on channel 5.
        timestamp = 100;
        dout[5*AB +: AB] = 10'h2A5;
        done[5] = 1'b1;
        tick();
        chk("single_n1_valid", evt.event_valid, 1'b0);
        tick();
        expect_ev("single", 5, 10'h2A5, 100, 1'b0, 1'b1);
        tick();

        // Backpressure and overflow on channel 3.
        evt.event_ready = 1'b0;
        for (int d = 1; d <= 6; d++) begin
            dout[3*AB +: AB] = AB'(d);
            done[3] = 1'b1;
            tick();
        end
        tick();
        tick();
        expect_ev("bp_hold", 3, 1, 0, 1'b0, 1'b0);
        chk("bp_fifo_full3", fifo_full[3], 1'b1);
        chk("bp_drop_count", drop_count, 1);
        evt.event_ready = 1'b1;
        for (int d = 2; d <= 5; d++) begin
            tick();
            expect_ev("bp_drain", 3, AB'(d), 0, (d == 2), 1'b0);
        end
        tick();
        chk("bp_done_idle", evt.event_valid, 1'b0);

        // Mask on channel 7.
        mask[7] = 1'b1;
        done[7] = 1'b1;
        tick();
        repeat (3) begin
            tick();
            chk("mask_no_event", evt.event_valid, 1'b0);
        end
        chk("mask_no_drop", drop_count, 1);
        mask[7] = 1'b0;
        rand_dout();
        d7 = dout[7*AB +: AB];
        done[7] = 1'b1;
        tick();
        tick();
        expect_ev("unmask", 7, d7, 0, 1'b0, 1'b0);
        tick();

        // Saturation and clear: 5 pulses are absorbed, 20 are dropped.
        evt.event_ready = 1'b0;
        repeat (25) begin
            done[9] = 1'b1;
            tick();
        end
        chk("sat_drop_count", drop_count, 15);
        clear   = 1'b1;
        done[9] = 1'b1;
        tick();
        chk("clear_with_drop", drop_count, 1);
        clear = 1'b1;
        tick();
        chk("clear_alone", drop_count, 0);
        evt.event_ready = 1'b1;
        repeat (10) tick();

        // Randomized traffic, heavy then light, with a mid-run reset.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rand_dout();
            if (cyc % 100 == 0) mask = {$urandom, $urandom} & {$urandom, $urandom} &
                                       {$urandom, $urandom};
            if (cyc < 1500) done = {$urandom, $urandom} & {$urandom, $urandom} &
                                   {$urandom, $urandom};
            else if ($urandom_range(0, 1) == 1) done = 64'b1 << $urandom_range(0, 63);
            clear           = ($urandom_range(0, 19) == 0);
            evt.event_ready = ($urandom_range(0, 3) != 0);
            reset_n         = !(cyc == 700 || cyc == 701);
            tick();
        end

        // Drain everything still queued.
        mask            = '0;
        evt.event_ready = 1'b1;
        repeat (300) tick();
        chk("drain_queue_empty", expq.size(), 0);
        chk("drain_idle", evt.event_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
